elevator_ctrl_n: RTL and testbench
==================================

ELEVATOR_CTRL_N -- requirements
Module: elevator_ctrl_n

Interface
- REQ-001: Parameter FLOORS, default 4, number of served floors (2..16).
- REQ-002: Parameter MOVE_TICKS, default 2000, clk_1khz cycles to travel one floor.
- REQ-003: Parameter DOOR_TICKS, default 3000, clk_1khz cycles the door stays open.
- REQ-004: Localparam PW = clog2(FLOORS), the position width.
- REQ-005: clk_1khz  input  1  the only clock; all state updates on its rising edge.
- REQ-006: rst_n  input  1  synchronous, active-low reset.
- REQ-007: car_req  input  FLOORS  in-car floor buttons, one bit per floor, level or pulse.
- REQ-008: hall_up  input  FLOORS  hall up buttons; bit FLOORS-1 is ignored.
- REQ-009: hall_dn  input  FLOORS  hall down buttons; bit 0 is ignored.
- REQ-010: position  output  PW  current floor, 0 = ground.
- REQ-011: head  output  1  travel direction: 1 = up, 0 = down.
- REQ-012: stop  output  1  1 when the car is stationary (any state except MOVE).
- REQ-013: empty  output  1  1 when no request is pending.
- REQ-014: door_open  output  1  1 in state DOOR.
- REQ-015: pend_car, pend_up, pend_dn  output  FLOORS each  latched request lamps.

Function
- REQ-016: Button bits SHALL be latched into pend_* one cycle after being sampled high, and SHALL stay set until serviced.
- REQ-017: The FSM SHALL have four states: IDLE, MOVE, ARRIVE, DOOR.
- REQ-018: A floor f is serviceable when any of these holds: pend_car[f]; head=1 and pend_up[f]; head=0 and pend_dn[f]; or a request exists at f and none exists beyond f in the head direction.
- REQ-019: IDLE, request at position: go to DOOR next cycle.
- REQ-020: IDLE, requests only elsewhere: set head toward them (up has priority when requests exist on both sides) and go to MOVE.
- REQ-021: MOVE: a tick counter SHALL run 0..MOVE_TICKS-1; at terminal count, position SHALL step by ±1 per head and the FSM SHALL go to ARRIVE.
- REQ-022: ARRIVE lasts one cycle: go to DOOR if the new position is serviceable, otherwise return to MOVE with the counter cleared.
- REQ-023: DOOR entry SHALL clear the serviced bits at position: pend_car, plus pend_up or pend_dn per head (both when reversing at that floor).
- REQ-024: DOOR SHALL last DOOR_TICKS cycles. A new request at the current floor during DOOR SHALL be cleared and SHALL restart the timer.
- REQ-025: On DOOR expiry, continue in head direction if requests remain ahead; otherwise reverse head if requests remain behind; otherwise go to IDLE.
- REQ-026: head SHALL be forced to 1 at position 0 and to 0 at position FLOORS-1; position SHALL never leave 0..FLOORS-1.
- REQ-027: A button pressed in the same cycle its bit is cleared SHALL leave that bit set, unless it is at the current floor in DOOR (REQ-024).
- REQ-028: empty SHALL be the NOR of all pend_* bits, registered.

Reset
- REQ-029: With rst_n=0 at a clock edge: state=IDLE, position=0, head=1, stop=1, empty=1, door_open=0, all pend_*=0, counters=0.
- REQ-030: Reset asserted mid-MOVE or mid-DOOR SHALL abort the operation; the car is treated as homed at floor 0.

Structure
- REQ-031: Package elevator_pkg SHALL hold the state enumeration and the default values of FLOORS, MOVE_TICKS and DOOR_TICKS.
- REQ-032: Sub-module elevator_req_bank SHALL hold the three pend_* vectors with set/clear logic and ahead/behind reduction flags.

Verification (FLOORS=4, MOVE_TICKS=8, DOOR_TICKS=4)
- REQ-033: Reset, then car_req[0] pulse -> DOOR at floor 0 two cycles later, door_open high 4 cycles, then IDLE, empty=1.
- REQ-034: car_req[3] from IDLE at 0 -> 3 floors x (8 MOVE + 1 ARRIVE) cycles, position 3, DOOR, pend_car[3] cleared.
- REQ-035: Car moving up from floor 0, hall_dn[1] and car_req[3] pending -> passes floor 1, stops at 3, reverses, stops at 1, head=0.
- REQ-036: hall_up[2] pressed during DOOR at floor 2 with head=1 -> bit never lamps longer than 1 cycle; door timer restarts.
- REQ-037: rst_n=0 for one edge mid-MOVE at position 2 -> next cycle position=0, IDLE, all pend_*=0.
- REQ-038: hall_up[3] and hall_dn[0] asserted -> ignored, empty stays 1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared state encoding and default sizing for the elevator controller.
package elevator_pkg;

  localparam int FLOORS_DEF     = 4;
  localparam int MOVE_TICKS_DEF = 2000;
  localparam int DOOR_TICKS_DEF = 3000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2,
    DOOR   = 2'd3
  } state_t;

endpackage

// File: rtl/elevator_req_bank.sv
// Latched request lamps with per-floor clearing, plus here/above/below
// reductions relative to the current car position.
module elevator_req_bank
  import elevator_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEF,
  parameter int PW     = $clog2(FLOORS)
) (
  input  logic              clk_1khz,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] car_req,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
  input  logic [PW-1:0]     position,
  input  logic              clr_car,
  input  logic              clr_up,
  input  logic              clr_dn,
  input  logic              hold,
  output logic [FLOORS-1:0] pend_car,
  output logic [FLOORS-1:0] pend_up,
  output logic [FLOORS-1:0] pend_dn,
  output logic              empty,
  output logic              here,
  output logic              above,
  output logic              below,
  output logic              hit
);

  // No up button on the top floor, no down button on the ground floor.
  localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [FLOORS-1:0] at, up_in, dn_in, cc, cu, cd, bc, bu, bd;
  logic [FLOORS-1:0] car_n, up_n, dn_n, any;

  always_comb begin
    at = '0;
    at[position] = 1'b1;
    up_in = hall_up & UP_OK;
    dn_in = hall_dn & DN_OK;
    cc = clr_car ? at : '0;
    cu = clr_up  ? at : '0;
    cd = clr_dn  ? at : '0;
    // While the door is open a serviceable press at this floor never lamps.
    bc = hold ? cc : '0;
    bu = hold ? cu : '0;
    bd = hold ? cd : '0;
    car_n = (pend_car & ~cc) | (car_req & ~bc);
    up_n  = (pend_up  & ~cu) | (up_in   & ~bu);
    dn_n  = (pend_dn  & ~cd) | (dn_in   & ~bd);
    hit   = |((bc & car_req) | (bu & up_in) | (bd & dn_in));
  end

  always_comb begin
    any   = pend_car | pend_up | pend_dn;
    here  = any[position];
    above = 1'b0;
    below = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      if (f > int'(position)) above = above | any[f];
      if (f < int'(position)) below = below | any[f];
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      pend_car <= '0;
      pend_up  <= '0;
      pend_dn  <= '0;
      empty    <= 1'b1;
    end else begin
      pend_car <= car_n;
      pend_up  <= up_n;
      pend_dn  <= dn_n;
      empty    <= ~|{car_n, up_n, dn_n};
    end
  end

endmodule

// File: rtl/elevator_ctrl_n.sv
// Single-car elevator controller: collective up/down sweep with a timed
// move per floor and a timed door that restarts on presses at its floor.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int FLOORS     = FLOORS_DEF,
  parameter int MOVE_TICKS = MOVE_TICKS_DEF,
  parameter int DOOR_TICKS = DOOR_TICKS_DEF,
  localparam int PW        = $clog2(FLOORS)
) (
  input  logic              clk_1khz,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] car_req,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
  output logic [PW-1:0]     position,
  output logic              head,
  output logic              stop,
  output logic              empty,
  output logic              door_open,
  output logic [FLOORS-1:0] pend_car,
  output logic [FLOORS-1:0] pend_up,
  output logic [FLOORS-1:0] pend_dn,
  output state_t            state
);

  localparam int CMAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  logic [CW-1:0] cnt;
  logic here, above, below, hit;
  logic ahead, behind, serviceable, enter_door, in_door, m_up, m_dn;

  always_comb begin
    ahead  = head ? above : below;
    behind = head ? below : above;
    serviceable = pend_car[position] | (head & pend_up[position]) |
                  (~head & pend_dn[position]) | (here & ~ahead);
    enter_door = ((state == IDLE) & here) | ((state == ARRIVE) & serviceable);
    in_door    = (state == DOOR);
    // Opposite-direction hall call is served too when the car turns here.
    m_up = head | ~ahead;
    m_dn = ~head | ~ahead;
  end

  elevator_req_bank #(.FLOORS(FLOORS), .PW(PW)) u_bank (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .car_req  (car_req),
    .hall_up  (hall_up),
    .hall_dn  (hall_dn),
    .position (position),
    .clr_car  (enter_door | in_door),
    .clr_up   ((enter_door | in_door) & m_up),
    .clr_dn   ((enter_door | in_door) & m_dn),
    .hold     (in_door),
    .pend_car (pend_car),
    .pend_up  (pend_up),
    .pend_dn  (pend_dn),
    .empty    (empty),
    .here     (here),
    .above    (above),
    .below    (below),
    .hit      (hit)
  );

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      state     <= IDLE;
      position  <= '0;
      head      <= 1'b1;
      stop      <= 1'b1;
      door_open <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (here) begin
            state     <= DOOR;
            door_open <= 1'b1;
          end else if (above) begin
            head  <= 1'b1;
            state <= MOVE;
            stop  <= 1'b0;
          end else if (below) begin
            head  <= 1'b0;
            state <= MOVE;
            stop  <= 1'b0;
          end
        end
        MOVE: begin
          if (cnt == CW'(MOVE_TICKS - 1)) begin
            cnt   <= '0;
            state <= ARRIVE;
            stop  <= 1'b1;
            if (head) begin
              position <= position + 1'b1;
              if (position == PW'(FLOORS - 2)) head <= 1'b0;
            end else begin
              position <= position - 1'b1;
              if (position == PW'(1)) head <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARRIVE: begin
          cnt <= '0;
          if (serviceable) begin
            state     <= DOOR;
            door_open <= 1'b1;
          end else begin
            state <= MOVE;
            stop  <= 1'b0;
          end
        end
        DOOR: begin
          if (hit) begin
            cnt <= '0;
          end else if (cnt == CW'(DOOR_TICKS - 1)) begin
            cnt       <= '0;
            door_open <= 1'b0;
            if (ahead) begin
              state <= MOVE;
              stop  <= 1'b0;
            end else if (behind) begin
              head  <= ~head;
              state <= MOVE;
              stop  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed scenario bench for elevator_ctrl_n (4 floors, 8-tick move, 4-tick door).
module tb_elevator_ctrl_n;
  import elevator_pkg::*;

  logic       clk_1khz = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] car_req = '0;
  logic [3:0] hall_up = '0;
  logic [3:0] hall_dn = '0;
  logic [1:0] position;
  logic       head, stop, empty, door_open;
  logic [3:0] pend_car, pend_up, pend_dn;
  state_t     state;

  int checks = 0;
  int errors = 0;

  elevator_ctrl_n #(.FLOORS(4), .MOVE_TICKS(8), .DOOR_TICKS(4)) dut (
    .clk_1khz  (clk_1khz),
    .rst_n     (rst_n),
    .car_req   (car_req),
    .hall_up   (hall_up),
    .hall_dn   (hall_dn),
    .position  (position),
    .head      (head),
    .stop      (stop),
    .empty     (empty),
    .door_open (door_open),
    .pend_car  (pend_car),
    .pend_up   (pend_up),
    .pend_dn   (pend_dn),
    .state     (state)
  );

  // clock / reset
  always #5 clk_1khz = ~clk_1khz;

  task automatic tick();
    @(posedge clk_1khz);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    car_req = '0;
    hall_up = '0;
    hall_dn = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (state !== IDLE || position !== 2'd0 || head !== 1'b1 || stop !== 1'b1) begin
      errors++;
      $display("FAIL reset_fsm state=%0d pos=%0d head=%b stop=%b want 0 0 1 1",
               state, position, head, stop);
    end
    checks++;
    if (empty !== 1'b1 || door_open !== 1'b0 || {pend_car, pend_up, pend_dn} !== 12'h000) begin
      errors++;
      $display("FAIL reset_lamps empty=%b door=%b pend=%h want 1 0 000",
               empty, door_open, {pend_car, pend_up, pend_dn});
    end
  endtask

  task automatic test_door_at_ground();
    apply_reset();
    car_req = 4'b0001;
    tick();
    car_req = '0;
    checks++;
    if (pend_car !== 4'b0001 || door_open !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL ground_latch pend_car=%b door=%b empty=%b want 0001 0 0",
               pend_car, door_open, empty);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (state !== DOOR || door_open !== 1'b1 || stop !== 1'b1 || pend_car !== 4'b0000 || empty !== 1'b1) begin
        errors++;
        $display("FAIL ground_door cyc=%0d state=%0d door=%b stop=%b pend_car=%b empty=%b want 3 1 1 0000 1",
                 i, state, door_open, stop, pend_car, empty);
      end
    end
    tick();
    checks++;
    if (state !== IDLE || door_open !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL ground_close state=%0d door=%b empty=%b want 0 0 1", state, door_open, empty);
    end
  endtask

  task automatic test_travel_up();
    apply_reset();
    car_req = 4'b1000;
    tick();
    car_req = '0;
    checks++;
    if (pend_car !== 4'b1000 || state !== IDLE || empty !== 1'b0) begin
      errors++;
      $display("FAIL travel_latch pend_car=%b state=%0d empty=%b want 1000 0 0", pend_car, state, empty);
    end
    tick();
    checks++;
    if (state !== MOVE || stop !== 1'b0 || head !== 1'b1) begin
      errors++;
      $display("FAIL travel_start state=%0d stop=%b head=%b want 1 0 1", state, stop, head);
    end
    repeat (7) tick();
    checks++;
    if (state !== MOVE || position !== 2'd0) begin
      errors++;
      $display("FAIL travel_e8 state=%0d pos=%0d want 1 0", state, position);
    end
    tick();
    checks++;
    if (state !== ARRIVE || position !== 2'd1 || stop !== 1'b1) begin
      errors++;
      $display("FAIL travel_arrive1 state=%0d pos=%0d stop=%b want 2 1 1", state, position, stop);
    end
    repeat (18) tick();
    checks++;
    if (state !== ARRIVE || position !== 2'd3 || head !== 1'b0) begin
      errors++;
      $display("FAIL travel_arrive3 state=%0d pos=%0d head=%b want 2 3 0", state, position, head);
    end
    tick();
    checks++;
    if (state !== DOOR || door_open !== 1'b1 || pend_car !== 4'b0000) begin
      errors++;
      $display("FAIL travel_door state=%0d door=%b pend_car=%b want 3 1 0000", state, door_open, pend_car);
    end
  endtask

  task automatic test_pass_and_reverse();
    int   opens = 0;
    int   cyc1 = -1, cyc2 = -1;
    logic [1:0] pos1 = '0, pos2 = '0;
    logic head2 = 1'b1;
    logic prev = 1'b0;
    apply_reset();
    car_req = 4'b1000;
    hall_dn = 4'b0010;
    tick();
    car_req = '0;
    hall_dn = '0;
    for (int cyc = 1; cyc <= 200 && opens < 2; cyc++) begin
      tick();
      if (door_open && !prev) begin
        if (opens == 0) begin
          cyc1 = cyc;
          pos1 = position;
        end else begin
          cyc2 = cyc;
          pos2 = position;
          head2 = head;
        end
        opens++;
      end
      prev = door_open;
    end
    checks++;
    if (opens !== 2) begin
      errors++;
      $display("FAIL reverse_timeout opens=%0d want 2", opens);
    end
    checks++;
    if (cyc1 !== 28 || pos1 !== 2'd3) begin
      errors++;
      $display("FAIL reverse_first cyc=%0d pos=%0d want 28 3", cyc1, pos1);
    end
    checks++;
    if (cyc2 !== 50 || pos2 !== 2'd1 || head2 !== 1'b0 || pend_dn !== 4'b0000) begin
      errors++;
      $display("FAIL reverse_second cyc=%0d pos=%0d head=%b pend_dn=%b want 50 1 0 0000",
               cyc2, pos2, head2, pend_dn);
    end
  endtask

  task automatic test_door_restart();
    apply_reset();
    car_req = 4'b0100;
    tick();
    car_req = '0;
    repeat (19) tick();
    checks++;
    if (state !== DOOR || position !== 2'd2 || head !== 1'b1) begin
      errors++;
      $display("FAIL restart_setup state=%0d pos=%0d head=%b want 3 2 1", state, position, head);
    end
    tick();
    hall_up = 4'b0100;
    tick();
    hall_up = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (door_open !== 1'b1 || pend_up !== 4'b0000) begin
        errors++;
        $display("FAIL restart_hold cyc=%0d door=%b pend_up=%b want 1 0000", i, door_open, pend_up);
      end
      tick();
    end
    checks++;
    if (door_open !== 1'b0 || state !== IDLE || empty !== 1'b1) begin
      errors++;
      $display("FAIL restart_close door=%b state=%0d empty=%b want 0 0 1", door_open, state, empty);
    end
  endtask

  task automatic test_reset_mid_move();
    apply_reset();
    car_req = 4'b1000;
    hall_dn = 4'b0010;
    tick();
    car_req = '0;
    hall_dn = '0;
    repeat (20) tick();
    checks++;
    if (state !== MOVE || position !== 2'd2 || pend_dn !== 4'b0010) begin
      errors++;
      $display("FAIL midmove_setup state=%0d pos=%0d pend_dn=%b want 1 2 0010", state, position, pend_dn);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (state !== IDLE || position !== 2'd0 || head !== 1'b1 || stop !== 1'b1 ||
        {pend_car, pend_up, pend_dn} !== 12'h000 || empty !== 1'b1) begin
      errors++;
      $display("FAIL midmove_reset state=%0d pos=%0d head=%b stop=%b pend=%h empty=%b want 0 0 1 1 000 1",
               state, position, head, stop, {pend_car, pend_up, pend_dn}, empty);
    end
    repeat (3) tick();
    checks++;
    if (state !== IDLE || position !== 2'd0) begin
      errors++;
      $display("FAIL midmove_after state=%0d pos=%0d want 0 0", state, position);
    end
  endtask

  task automatic test_ignored_bits();
    apply_reset();
    hall_up = 4'b1000;
    hall_dn = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (empty !== 1'b1 || pend_up !== 4'b0000 || pend_dn !== 4'b0000 || state !== IDLE) begin
        errors++;
        $display("FAIL ignored cyc=%0d empty=%b up=%b dn=%b state=%0d want 1 0000 0000 0",
                 i, empty, pend_up, pend_dn, state);
      end
    end
    hall_up = '0;
    hall_dn = '0;
  endtask

  initial begin
    test_reset();
    test_door_at_ground();
    test_travel_up();
    test_pass_and_reverse();
    test_door_restart();
    test_reset_mid_move();
    test_ignored_bits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
